// File: rtl/keypad_if.sv
// keypad_if: debounced key handshake between the keypad scanner and its consumer
interface keypad_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;
    modport master (output key_code, key_valid, key_held, overrun, input key_ack);
    modport slave  (input key_code, key_valid, key_held, overrun, output key_ack);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scan, debounce and valid/ack key register
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    keypad_if.master   kif
);
    localparam int            DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [7:0]    DEB_LAST = 8'(DEBOUNCE_SCANS - 1);
    localparam bit            DEB_ONE  = DEBOUNCE_SCANS == 1;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t        state;
    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] div;
    logic [1:0]    col_idx;
    logic [15:0]   snap;
    logic          scan_end;
    logic [7:0]    cnt;
    logic [3:0]    cand, code;
    logic          single, cand_set, accept;

    assign col = ~(4'b0001 << col_idx);

    // synchronize the rows, pace the column drive and capture each column's pressed rows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1   <= 4'hf;
            row_s2   <= 4'hf;
            div      <= '0;
            col_idx  <= '0;
            snap     <= '0;
            scan_end <= 1'b0;
        end else begin
            row_s1   <= row;
            row_s2   <= row_s1;
            div      <= (div == DIV_LAST) ? '0 : div + 1'b1;
            scan_end <= (div == DIV_LAST) && (col_idx == 2'd3);
            if (div == DIV_LAST) begin
                snap[{col_idx, 2'b00} +: 4] <= ~row_s2;
                col_idx                     <= col_idx + 1'b1;
            end
        end
    end

    // classify the finished scan; snapshot bit c*4+r corresponds to key code r*4+c
    always_comb begin
        code = '0;
        for (int i = 0; i < 16; i++)
            if (snap[i]) code = {i[1:0], i[3:2]};
        single   = (snap != '0) && ((snap & (snap - 16'd1)) == '0);
        cand_set = snap[{cand[1:0], cand[3:2]}];
        accept   = scan_end && single &&
                   ((state == IDLE && DEB_ONE) ||
                    (state == PRESS_WAIT && code == cand && cnt == DEB_LAST));
    end

    // debounce state machine plus the key holding register and its handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            cand          <= '0;
            kif.key_code  <= '0;
            kif.key_valid <= 1'b0;
            kif.key_held  <= 1'b0;
            kif.overrun   <= 1'b0;
        end else begin
            if (scan_end) begin
                case (state)
                    IDLE:
                        if (single) begin
                            cand         <= code;
                            cnt          <= 8'd1;
                            state        <= DEB_ONE ? HELD : PRESS_WAIT;
                            kif.key_held <= DEB_ONE;
                        end
                    PRESS_WAIT:
                        if (single && code == cand) begin
                            cnt <= cnt + 8'd1;
                            if (cnt == DEB_LAST) begin
                                state        <= HELD;
                                kif.key_held <= 1'b1;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    HELD:
                        if (!cand_set) begin
                            cnt          <= DEB_ONE ? 8'd0 : 8'd1;
                            state        <= DEB_ONE ? IDLE : RELEASE_WAIT;
                            kif.key_held <= !DEB_ONE;
                        end
                    RELEASE_WAIT:
                        if (cand_set) begin
                            state <= HELD;
                        end else if (cnt == DEB_LAST) begin
                            cnt          <= '0;
                            state        <= IDLE;
                            kif.key_held <= 1'b0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    default: state <= IDLE;
                endcase
            end
            if (accept) begin
                kif.key_code  <= code;
                kif.key_valid <= 1'b1;
                kif.overrun   <= !kif.key_ack && (kif.key_valid || kif.overrun);
            end else if (kif.key_ack) begin
                kif.key_valid <= 1'b0;
                kif.overrun   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scan-level random and directed checks against a debounce model
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row, col;
    logic [15:0] keys  = '0;
    int          checks = 0, errors = 0;
    int          m_held, m_pk, m_streak, m_rel, m_code;
    bit          m_valid, m_ovr;

    keypad_if kif();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .kif(kif)
    );

    always #5 clk = ~clk;

    // a pressed key (r,c) pulls row r low while column c is driven low
    always_comb
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = -1; m_pk = 0; m_streak = 0; m_rel = 0;
        m_code = 0; m_valid = 0; m_ovr = 0;
    endtask

    // one full scan seen as a set of pressed keys; acks before or on the evaluation edge
    task automatic model_scan(input logic [15:0] p, input bit ack_pre, input bit ack_same);
        bit acc = 0;
        int k = -1;
        if (ack_pre) begin m_valid = 0; m_ovr = 0; end
        if ($countones(p) == 1)
            for (int i = 0; i < 16; i++) if (p[i]) k = i;
        if (m_held < 0) begin
            if (k >= 0 && (m_streak == 0 || k == m_pk)) begin
                m_streak++;
                m_pk = k;
            end else m_streak = 0;
            if (m_streak == DEB) begin acc = 1; m_held = k; m_streak = 0; end
        end else begin
            m_rel = p[m_held] ? 0 : m_rel + 1;
            if (m_rel == DEB) begin m_held = -1; m_rel = 0; end
        end
        if (acc) begin
            m_ovr   = !ack_same && m_valid;
            m_valid = 1;
            m_code  = k;
        end else if (ack_same) begin
            m_valid = 0;
            m_ovr   = 0;
        end
    endtask

    task automatic check_outs();
        check("key_valid", kif.key_valid, m_valid);
        check("key_code", kif.key_code, m_code);
        check("key_held", kif.key_held, m_held >= 0);
        check("overrun", kif.overrun, m_ovr);
    endtask

    // runs from the negedge after one evaluation edge to the negedge after the next
    task automatic scan(input logic [15:0] p, input bit ack, input int at);
        keys = p;
        for (int k = 1; k <= 16; k++) begin
            kif.key_ack = ack && (k == at);
            @(posedge clk);
            @(negedge clk);
        end
        kif.key_ack = 1'b0;
        model_scan(p, ack && at < 16, ack && at == 16);
        check_outs();
    endtask

    initial begin
        logic [15:0] p;
        logic [3:0]  exp_col;
        p = '0;
        kif.key_ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset col", col, 4'b1110);
        check_outs();
        rst_n = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp_col = ~(4'b0001 << ((n / 4) % 4));
            check("col walk", col, exp_col);
        end
        model_scan(16'h0, 0, 0);
        check_outs();

        // clean press of (2,1), ack, keep holding, release
        repeat (3) scan(16'h0200, 0, 0);
        scan(16'h0200, 1, 4);
        repeat (2) scan(16'h0200, 0, 0);
        repeat (3) scan(16'h0000, 0, 0);

        // bouncing (0,3) never stable for three scans, then held steadily
        foreach (p[i]) if (i < 10) scan((16'b0110101101 >> i) & 16'h1 ? 16'h0008 : 16'h0000, 0, 0);
        repeat (3) scan(16'h0000, 0, 0);
        repeat (3) scan(16'h0008, 0, 0);
        repeat (3) scan(16'h0000, 1, 2);

        // two keys at once are ignored until one is released
        repeat (3) scan(16'h4020, 0, 0);
        repeat (3) scan(16'h0020, 0, 0);
        repeat (3) scan(16'h0000, 1, 9);

        // overrun: key 0 left pending, then key 15 accepted over it
        repeat (3) scan(16'h0001, 0, 0);
        repeat (3) scan(16'h0000, 0, 0);
        repeat (3) scan(16'h8000, 0, 0);
        scan(16'h8000, 1, 7);
        repeat (3) scan(16'h0000, 0, 0);

        // accept coinciding with an ack of an older pending press
        repeat (3) scan(16'h0040, 0, 0);
        repeat (3) scan(16'h0000, 0, 0);
        repeat (2) scan(16'h0400, 0, 0);
        scan(16'h0400, 1, 16);
        repeat (3) scan(16'h0000, 1, 16);

        // press pending, reset in the middle of PRESS_WAIT for key 12
        repeat (3) scan(16'h0002, 0, 0);
        repeat (2) scan(16'h1000, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst col", col, 4'b1110);
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (3) scan(16'h1000, 0, 0);
        repeat (3) scan(16'h0000, 1, 5);

        // random key activity, mostly held for several scans
        for (int s = 0; s < 200; s++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 6) p = '0;
            else if (r == 7 || r == 8) p = 16'h1 << $urandom_range(0, 15);
            else if (r == 9) p = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            scan(p, $urandom_range(0, 3) == 0, $urandom_range(1, 16));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
